hello_uart_tx: RTL and testbench

- Downstream output stage for the hello_world greeting block.
- Serialises the fixed ASCII message "Hello\n" onto a single UART line (8N1, LSB first) each time it receives a start pulse.
- Gives synthesizable hardware an observable output where simulation only has $display.
- Sits at the top-level pin boundary and drives the board TX pin.

---
 rtl/hello_uart_tx.sv | 116 +++++++++++
 tb/tb_hello_uart_tx.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/hello_uart_tx.sv
// UART transmitter that sends the fixed message "Hello\n" (8N1, LSB first) on each start request.
// All outputs are registered; tx idles high and is forced high asynchronously by rst.
module hello_uart_tx #(
  parameter int unsigned CLKS_PER_BIT = 4,
  parameter int unsigned MSG_LEN      = 6
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  output logic       tx,
  output logic       busy,
  output logic       done,
  output logic [2:0] char_idx
);

  localparam logic [15:0] LastCnt = 16'(CLKS_PER_BIT - 1);
  localparam logic [2:0]  LastIdx = 3'(MSG_LEN - 1);

  if (CLKS_PER_BIT < 2 || CLKS_PER_BIT > 65535) begin : g_bad_clks_per_bit
    $error("hello_uart_tx: CLKS_PER_BIT must be in 2..65535");
  end

  if (MSG_LEN != 6) begin : g_bad_msg_len
    $error("hello_uart_tx: MSG_LEN must be 6");
  end

  typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_t;

  state_t      state;
  logic [15:0] baud_cnt;
  logic [2:0]  bit_idx;
  logic [7:0]  cur_byte;

  always_comb begin
    cur_byte = 8'h00;
    case (char_idx)
      3'd0:    cur_byte = 8'h48;
      3'd1:    cur_byte = 8'h65;
      3'd2:    cur_byte = 8'h6C;
      3'd3:    cur_byte = 8'h6C;
      3'd4:    cur_byte = 8'h6F;
      3'd5:    cur_byte = 8'h0A;
      default: cur_byte = 8'h00;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= StIdle;
      tx       <= 1'b1;
      busy     <= 1'b0;
      done     <= 1'b0;
      char_idx <= 3'd0;
      baud_cnt <= 16'd0;
      bit_idx  <= 3'd0;
    end else begin
      done <= 1'b0;
      unique case (state)
        StIdle: begin
          baud_cnt <= 16'd0;
          bit_idx  <= 3'd0;
          if (start) begin
            state    <= StStart;
            tx       <= 1'b0;
            busy     <= 1'b1;
            char_idx <= 3'd0;
          end
        end
        StStart: begin
          if (baud_cnt == LastCnt) begin
            baud_cnt <= 16'd0;
            bit_idx  <= 3'd0;
            tx       <= cur_byte[0];
            state    <= StData;
          end else begin
            baud_cnt <= baud_cnt + 16'd1;
          end
        end
        StData: begin
          if (baud_cnt == LastCnt) begin
            baud_cnt <= 16'd0;
            if (bit_idx == 3'd7) begin
              tx    <= 1'b1;
              state <= StStop;
            end else begin
              tx      <= cur_byte[bit_idx + 3'd1];
              bit_idx <= bit_idx + 3'd1;
            end
          end else begin
            baud_cnt <= baud_cnt + 16'd1;
          end
        end
        StStop: begin
          if (baud_cnt == LastCnt) begin
            baud_cnt <= 16'd0;
            if (char_idx == LastIdx) begin
              state    <= StIdle;
              busy     <= 1'b0;
              done     <= 1'b1;
              char_idx <= 3'd0;
            end else begin
              // Next frame follows immediately with no idle gap.
              char_idx <= char_idx + 3'd1;
              tx       <= 1'b0;
              state    <= StStart;
            end
          end else begin
            baud_cnt <= baud_cnt + 16'd1;
          end
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_hello_uart_tx.sv
// Bench for hello_uart_tx: a software UART receiver decodes tx and checks bytes against a
// scoreboard queue filled when start is driven; two instances cover CLKS_PER_BIT of 4 and 2.
module tb_hello_uart_tx;

  logic       clk = 1'b0;
  logic       rst, start, rst2, start2;
  logic       tx4, busy4, done4, tx2, busy2, done2;
  logic [2:0] idx4, idx2;

  hello_uart_tx #(.CLKS_PER_BIT(4), .MSG_LEN(6)) dut4 (
    .clk(clk), .rst(rst), .start(start), .tx(tx4), .busy(busy4), .done(done4), .char_idx(idx4)
  );

  hello_uart_tx #(.CLKS_PER_BIT(2), .MSG_LEN(6)) dut2 (
    .clk(clk), .rst(rst2), .start(start2), .tx(tx2), .busy(busy2), .done(done2), .char_idx(idx2)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  logic [7:0] exp_q[$];
  logic       tx_log[1024];
  logic       busy_log[1024];
  int         busy_cnt, done_cnt, done_first, done_last, idle_bad;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push_msg();
    exp_q.push_back(8'h48);
    exp_q.push_back(8'h65);
    exp_q.push_back(8'h6C);
    exp_q.push_back(8'h6C);
    exp_q.push_back(8'h6F);
    exp_q.push_back(8'h0A);
  endtask

  // Cycle 0 is the first negedge after the edge that samples start.
  // start is released after cycle rel; one-cycle pulses at p1/p2; rst raised at cycle rst_at.
  task automatic watch(input bit sel, input int ncyc, input int rel, input int p1, input int p2,
                       input int rst_at);
    int         n;
    bit         rx_act;
    int         rx_cnt, bnum;
    logic [7:0] rx_byte, exp_b;
    logic       t, b, d;
    logic [2:0] ci;
    n = sel ? 2 : 4;
    rx_act = 1'b0;
    rx_cnt = 0;
    rx_byte = 8'h00;
    busy_cnt = 0;
    done_cnt = 0;
    done_first = -1;
    done_last = -1;
    idle_bad = 0;
    for (int c = 0; c < ncyc; c++) begin
      @(negedge clk);
      t  = sel ? tx2 : tx4;
      b  = sel ? busy2 : busy4;
      d  = sel ? done2 : done4;
      ci = sel ? idx2 : idx4;
      if (c < 1024) begin
        tx_log[c]   = t;
        busy_log[c] = b;
      end
      if (b) busy_cnt++;
      if (d) begin
        done_cnt++;
        if (done_first < 0) done_first = c;
        done_last = c;
      end
      if ((!b && ci != 3'd0) || ci > 3'd5) idle_bad++;
      if (!rx_act && t == 1'b0) begin
        rx_act = 1'b1;
        rx_cnt = 0;
      end
      if (rx_act) begin
        if (rx_cnt % n == n / 2) begin
          bnum = rx_cnt / n;
          if (bnum == 0) begin
            chk("start_bit", {31'd0, t}, 32'd0);
          end else if (bnum <= 8) begin
            rx_byte[bnum-1] = t;
          end else begin
            chk("stop_bit", {31'd0, t}, 32'd1);
            if (exp_q.size() == 0) begin
              chk("rx_extra_byte", {24'd0, rx_byte}, 32'hFFFF_FFFF);
            end else begin
              exp_b = exp_q.pop_front();
              chk("rx_byte", {24'd0, rx_byte}, {24'd0, exp_b});
            end
            rx_act = 1'b0;
          end
        end
        rx_cnt++;
      end
      if (c == rel || c == p1 + 1 || c == p2 + 1) begin
        if (sel) start2 = 1'b0;
        else start = 1'b0;
      end
      if (c == p1 || c == p2) begin
        if (sel) start2 = 1'b1;
        else start = 1'b1;
      end
      if (c == rst_at && !sel) begin
        rst = 1'b1;
        #1;
        chk("async_rst_tx", {31'd0, tx4}, 32'd1);
        chk("async_rst_busy", {31'd0, busy4}, 32'd0);
        chk("async_rst_idx", {29'd0, idx4}, 32'd0);
        exp_q.delete();
        rx_act = 1'b0;
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b1;
    rst2 = 1'b1;
    start2 = 1'b0;

    // Reset held with start high: outputs stay at reset values.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rst_tx", {31'd0, tx4}, 32'd1);
      chk("rst_busy", {31'd0, busy4}, 32'd0);
      chk("rst_done", {31'd0, done4}, 32'd0);
      chk("rst_idx", {29'd0, idx4}, 32'd0);
    end

    // Release reset with start high: sampled on the first edge, then dropped.
    rst = 1'b0;
    push_msg();
    watch(1'b0, 260, 0, -10, -10, -1);
    chk("single_latency_tx", {31'd0, tx_log[0]}, 32'd0);
    chk("single_busy_cnt", busy_cnt, 32'd240);
    chk("single_done_cnt", done_cnt, 32'd1);
    chk("single_done_cycle", done_first, 32'd240);
    chk("single_busy_fall", {31'd0, busy_log[240]}, 32'd0);
    chk("single_rx_missing", exp_q.size(), 32'd0);
    chk("single_idx_range", idle_bad, 32'd0);

    // Extra start pulses while busy are ignored.
    start = 1'b1;
    push_msg();
    watch(1'b0, 260, 0, 50, 200, -1);
    chk("busy_start_busy_cnt", busy_cnt, 32'd240);
    chk("busy_start_done_cnt", done_cnt, 32'd1);
    chk("busy_start_rx_missing", exp_q.size(), 32'd0);

    // Continuous start: one idle cycle (the done cycle) between messages.
    start = 1'b1;
    push_msg();
    push_msg();
    watch(1'b0, 490, 241, -10, -10, -1);
    chk("cont_busy_cnt", busy_cnt, 32'd480);
    chk("cont_done_cnt", done_cnt, 32'd2);
    chk("cont_done_first", done_first, 32'd240);
    chk("cont_done_last", done_last, 32'd481);
    chk("cont_gap_tx", {31'd0, tx_log[240]}, 32'd1);
    chk("cont_gap_busy", {31'd0, busy_log[240]}, 32'd0);
    chk("cont_restart_tx", {31'd0, tx_log[241]}, 32'd0);
    chk("cont_restart_busy", {31'd0, busy_log[241]}, 32'd1);
    chk("cont_rx_missing", exp_q.size(), 32'd0);
    chk("cont_idx_range", idle_bad, 32'd0);

    // Asynchronous reset mid-frame (char 2, data phase).
    start = 1'b1;
    push_msg();
    watch(1'b0, 120, 0, -10, -10, 100);
    chk("abort_done_cnt", done_cnt, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("abort_no_resume_tx", {31'd0, tx4}, 32'd1);
    chk("abort_no_resume_busy", {31'd0, busy4}, 32'd0);
    start = 1'b1;
    push_msg();
    watch(1'b0, 260, 0, -10, -10, -1);
    chk("fresh_busy_cnt", busy_cnt, 32'd240);
    chk("fresh_done_cnt", done_cnt, 32'd1);
    chk("fresh_rx_missing", exp_q.size(), 32'd0);

    // CLKS_PER_BIT = 2 instance.
    rst2 = 1'b0;
    @(negedge clk);
    chk("cpb2_idle_tx", {31'd0, tx2}, 32'd1);
    start2 = 1'b1;
    push_msg();
    watch(1'b1, 140, 0, -10, -10, -1);
    chk("cpb2_latency_tx", {31'd0, tx_log[0]}, 32'd0);
    chk("cpb2_busy_cnt", busy_cnt, 32'd120);
    chk("cpb2_done_cnt", done_cnt, 32'd1);
    chk("cpb2_done_cycle", done_first, 32'd120);
    chk("cpb2_rx_missing", exp_q.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
